// File: rtl/m_wbtimer_if.sv
// Wishbone classic responder bundle for the m_wbtimer machine timer.
// Signal names follow the Wishbone port naming of the timer block.
interface m_wbtimer_if;
    logic        CYC_I;
    logic        STB_I;
    logic        WE_I;
    logic [1:0]  ADR_I;
    logic [3:0]  SEL_I;
    logic [31:0] DAT_I;
    logic [31:0] DAT_O;
    logic        ACK_O;

    modport master (
        output CYC_I, STB_I, WE_I, ADR_I, SEL_I, DAT_I,
        input  DAT_O, ACK_O
    );

    modport slave (
        input  CYC_I, STB_I, WE_I, ADR_I, SEL_I, DAT_I,
        output DAT_O, ACK_O
    );
endinterface

// File: rtl/m_wbtimer.sv
// Wishbone RISC-V style machine timer (MTIME/MTIMECMP, prescaled tick).
// Define M_WBTIMER_CMP_EN to build MTIMECMP and the MTIP compare.
module m_wbtimer #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    m_wbtimer_if.slave bus,
    output logic       MTIP_O
);
    localparam logic [15:0] PCNT_MAX = 16'(PRESCALE - 1);

    logic [63:0] mtime;
    logic [63:0] mtime_nx;
    logic [15:0] pcnt;
    logic [15:0] pcnt_nx;
    logic        ack;
    logic [31:0] dat;
    logic [31:0] rdata;
    logic [31:0] mask;
    logic        req;
    logic        wr;
    logic        wr_lo;
    logic        wr_hi;
    logic        tick;

    assign req   = bus.CYC_I & bus.STB_I & ~ack;
    assign wr    = req & bus.WE_I & (|bus.SEL_I);
    assign wr_lo = wr & (bus.ADR_I == 2'd0);
    assign wr_hi = wr & (bus.ADR_I == 2'd1);
    assign tick  = (pcnt == PCNT_MAX);
    assign mask  = {{8{bus.SEL_I[3]}}, {8{bus.SEL_I[2]}},
                    {8{bus.SEL_I[1]}}, {8{bus.SEL_I[0]}}};

    // A write to either MTIME half cancels this edge's increment entirely.
    always_comb begin
        mtime_nx = tick ? mtime + 64'd1 : mtime;
        pcnt_nx  = tick ? 16'd0 : pcnt + 16'd1;
        if (wr_lo) begin
            mtime_nx = {mtime[63:32],
                        (bus.DAT_I & mask) | (mtime[31:0] & ~mask)};
            pcnt_nx  = 16'd0;
        end
        if (wr_hi) begin
            mtime_nx = {(bus.DAT_I & mask) | (mtime[63:32] & ~mask),
                        mtime[31:0]};
            pcnt_nx  = 16'd0;
        end
    end

`ifdef M_WBTIMER_CMP_EN
    logic [63:0] mtimecmp;
    logic [63:0] cmp_nx;

    always_comb begin
        cmp_nx = mtimecmp;
        if (wr && bus.ADR_I == 2'd2)
            cmp_nx[31:0] = (bus.DAT_I & mask) | (mtimecmp[31:0] & ~mask);
        if (wr && bus.ADR_I == 2'd3)
            cmp_nx[63:32] = (bus.DAT_I & mask) | (mtimecmp[63:32] & ~mask);
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            mtimecmp <= '1;
            MTIP_O   <= 1'b0;
        end else begin
            mtimecmp <= cmp_nx;
            MTIP_O   <= (mtime >= mtimecmp);
        end
    end

    always_comb begin
        rdata = '0;
        unique case (bus.ADR_I)
            2'd0: rdata = mtime[31:0];
            2'd1: rdata = mtime[63:32];
            2'd2: rdata = mtimecmp[31:0];
            2'd3: rdata = mtimecmp[63:32];
        endcase
    end
`else
    assign MTIP_O = 1'b0;

    always_comb begin
        rdata = '0;
        unique case (bus.ADR_I)
            2'd0: rdata = mtime[31:0];
            2'd1: rdata = mtime[63:32];
            2'd2: rdata = '0;
            2'd3: rdata = '0;
        endcase
    end
`endif

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            mtime <= '0;
            pcnt  <= '0;
            ack   <= 1'b0;
            dat   <= '0;
        end else begin
            mtime <= mtime_nx;
            pcnt  <= pcnt_nx;
            ack   <= req;
            dat   <= req ? rdata : 32'd0;
        end
    end

    assign bus.ACK_O = ack;
    assign bus.DAT_O = dat;
endmodule

// File: doc/m_wbtimer.md
M_WBTIMER -- requirements
Module: m_wbtimer

Interface
REQ-001 SHALL have parameter PRESCALE, default 1, meaning CLK_I cycles per MTIME increment (legal 1..65535).
REQ-002 SHALL have port CLK_I  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port RST_I  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port CYC_I  input  1  Wishbone bus cycle valid.
REQ-005 SHALL have port STB_I  input  1  Wishbone strobe, this responder selected.
REQ-006 SHALL have port WE_I  input  1  1 = write, 0 = read.
REQ-007 SHALL have port ADR_I  input  2  word address: 0 MTIME[31:0], 1 MTIME[63:32], 2 MTIMECMP[31:0], 3 MTIMECMP[63:32].
REQ-008 SHALL have port SEL_I  input  4  byte enables for writes; SEL_I[n] enables DAT_I[8n+7:8n].
REQ-009 SHALL have port DAT_I  input  32  write data.
REQ-010 SHALL have port DAT_O  output  32  read data, valid while ACK_O=1, 0 otherwise.
REQ-011 SHALL have port ACK_O  output  1  transfer acknowledge.
REQ-012 SHALL have port MTIP_O  output  1  timer interrupt pending.

Function
REQ-013 SHALL hold registers MTIME (64 bit), MTIMECMP (64 bit), prescaler counter PCNT (16 bit).
REQ-014 SHALL increment PCNT every cycle; when PCNT = PRESCALE-1 it SHALL return to 0 and MTIME SHALL increment by 1 in that same edge.
REQ-015 SHALL wrap MTIME from 64'hFFFF_FFFF_FFFF_FFFF to 0 with no flag; carry from bit 31 to bit 32 SHALL occur within the same edge.
REQ-016 SHALL accept a request when CYC_I=1, STB_I=1, ACK_O=0; ACK_O SHALL be 1 in the next cycle only, then 0 for at least one cycle (one transfer per two cycles max).
REQ-017 SHALL perform accepted writes at the accepting edge, updating only bytes with SEL_I set; SEL_I=0 write SHALL be acknowledged with no state change.
REQ-018 SHALL drive DAT_O in the ACK cycle with the addressed register value sampled at the accepting edge (pre-increment value).
REQ-019 SHALL, on a write to MTIME (either half), let the written bytes win over a coincident increment; unwritten bytes of that half SHALL keep their pre-edge value and the other half SHALL not receive carry from that increment; PCNT SHALL clear to 0.
REQ-020 SHALL drive MTIP_O registered: MTIP_O = (MTIME >= MTIMECMP) evaluated on the post-edge register values, one cycle latency, unsigned 64-bit compare.
REQ-021 SHALL ignore STB_I when CYC_I=0; deasserting CYC_I during the ACK cycle SHALL not cancel the already performed write.

Reset
REQ-022 SHALL, while RST_I=1 at an edge, set MTIME=0, PCNT=0, MTIMECMP=64'hFFFF_FFFF_FFFF_FFFF, ACK_O=0, DAT_O=0, MTIP_O=0.
REQ-023 SHALL discard any request accepted coincident with reset; no ACK_O SHALL follow reset.
REQ-024 SHALL resume counting on the first edge with RST_I=0 (first increment after PRESCALE edges).

Configuration
REQ-025 SHALL use macro M_WBTIMER_CMP_EN to compile in MTIMECMP and the compare.
REQ-026 SHALL, with M_WBTIMER_CMP_EN defined, behave per REQ-013..REQ-024.
REQ-027 SHALL, without M_WBTIMER_CMP_EN, omit MTIMECMP and compare logic: MTIP_O tied 0, reads of ADR_I 2/3 return 0, writes to ADR_I 2/3 acknowledged and ignored.

Verification
REQ-028 SHALL cover: PRESCALE=1, release reset, read ADR 0 at cycle 10 -> DAT_O=10 in ACK cycle, ACK_O high exactly one cycle.
REQ-029 SHALL cover: write ADR 0=32'hFFFF_FFFF, ADR 1=0, PRESCALE=1 -> two cycles later read ADR 1 = 1, ADR 0 small value.
REQ-030 SHALL cover: PRESCALE=4, write MTIMECMP=100 -> MTIP_O rises exactly one cycle after MTIME reaches 100 (400 cycles from MTIME write of 0).
REQ-031 SHALL cover: write ADR 0 data 32'h1234_5678 SEL_I=4'b0010 coincident with increment -> byte 1 = 8'h56, other bytes pre-edge value, PCNT=0.
REQ-032 SHALL cover: STB_I held high continuously -> ACK_O toggles 1,0,1,0; RST_I asserted with request pending -> ACK_O stays 0, registers at reset values.
REQ-033 SHALL cover: build without M_WBTIMER_CMP_EN, write ADR 2=5, read ADR 2 -> 0, MTIP_O=0 throughout.
